// File: rtl/adam_pause_seq_if.sv
// Bundle shared by the pause sequencer, the system pause controller and the peripheral group.
// The slave modport is the sequencer's view; the master modport drives requests and acks.
interface adam_pause_seq_if #(
  parameter int unsigned NO_PERIPHS = 4
);
  localparam int unsigned IdxW = (NO_PERIPHS > 1) ? $clog2(NO_PERIPHS) : 1;

  logic                  pause_req;
  logic                  pause_ack;
  logic [NO_PERIPHS-1:0] skip;
  logic [NO_PERIPHS-1:0] periph_pause_req;
  logic [NO_PERIPHS-1:0] periph_pause_ack;
  logic                  err;
  logic [IdxW-1:0]       err_idx;

  modport master (
    output pause_req,
    output skip,
    output periph_pause_ack,
    input  pause_ack,
    input  periph_pause_req,
    input  err,
    input  err_idx
  );

  modport slave (
    input  pause_req,
    input  skip,
    input  periph_pause_ack,
    output pause_ack,
    output periph_pause_req,
    output err,
    output err_idx
  );
endinterface

// File: rtl/adam_pause_seq.sv
// Pause sequencer: pauses peripherals one at a time in ascending order, resumes them in
// descending order, with a per-peripheral ack timeout and reversible abort in either direction.
module adam_pause_seq #(
  parameter int unsigned NO_PERIPHS = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input logic              clk,
  input logic              rst,
  adam_pause_seq_if.slave  bus_io
);

  localparam int unsigned IdxW = (NO_PERIPHS > 1) ? $clog2(NO_PERIPHS) : 1;
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NO_PERIPHS - 1);
  // Step completes on the edge where the counter would reach TIMEOUT.
  localparam logic [CntW-1:0] TmoLim  = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    StRun,
    StPausing,
    StPaused,
    StResuming
  } state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [NO_PERIPHS-1:0] skip_q, skip_d;
  logic [NO_PERIPHS-1:0] req_q, req_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [IdxW-1:0]       err_idx_q, err_idx_d;

  logic            cur_skip;
  logic            cur_ack;
  logic            tmo_hit;
  logic [IdxW-1:0] idx_inc;
  logic [IdxW-1:0] idx_dec;

  always_comb begin
    cur_skip = skip_q[idx_q];
    cur_ack  = bus_io.periph_pause_ack[idx_q];
    tmo_hit  = (TIMEOUT != 0) && (cnt_q >= TmoLim);
    idx_inc  = idx_q + 1'b1;
    idx_dec  = idx_q - 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    skip_d    = skip_q;
    req_d     = req_q;
    ack_d     = ack_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;

    unique case (state_q)
      StRun: begin
        if (bus_io.pause_req) begin
          state_d = StPausing;
          idx_d   = '0;
          cnt_d   = '0;
          skip_d  = bus_io.skip;
          if (!bus_io.skip[0]) req_d[0] = 1'b1;
        end
      end

      StPausing: begin
        if (!bus_io.pause_req) begin
          // Abort: unwind from the current index without re-latching skip.
          state_d = StResuming;
          cnt_d   = '0;
          if (!cur_skip) req_d[idx_q] = 1'b0;
        end else if (cur_skip || cur_ack || tmo_hit) begin
          if (!cur_skip && !cur_ack) begin
            err_d     = 1'b1;
            err_idx_d = idx_q;
          end
          cnt_d = '0;
          if (idx_q == LastIdx) begin
            state_d = StPaused;
            ack_d   = 1'b1;
          end else begin
            idx_d = idx_inc;
            if (!skip_q[idx_inc]) req_d[idx_inc] = 1'b1;
          end
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StPaused: begin
        if (!bus_io.pause_req) begin
          state_d = StResuming;
          idx_d   = LastIdx;
          cnt_d   = '0;
          skip_d  = bus_io.skip;
          if (!bus_io.skip[NO_PERIPHS-1]) req_d[NO_PERIPHS-1] = 1'b0;
        end
      end

      StResuming: begin
        if (bus_io.pause_req) begin
          // Re-pause from the current index; the group is no longer fully paused.
          state_d = StPausing;
          ack_d   = 1'b0;
          cnt_d   = '0;
          if (!cur_skip) req_d[idx_q] = 1'b1;
        end else if (cur_skip || !cur_ack || tmo_hit) begin
          if (!cur_skip && cur_ack) begin
            err_d     = 1'b1;
            err_idx_d = idx_q;
          end
          cnt_d = '0;
          if (idx_q == '0) begin
            state_d = StRun;
            ack_d   = 1'b0;
          end else begin
            idx_d = idx_dec;
            if (!skip_q[idx_dec]) req_d[idx_dec] = 1'b0;
          end
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      idx_q     <= '0;
      cnt_q     <= '0;
      skip_q    <= '0;
      req_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      skip_q    <= skip_d;
      req_q     <= req_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign bus_io.periph_pause_req = req_q;
  assign bus_io.pause_ack        = ack_q;
  assign bus_io.err              = err_q;
  assign bus_io.err_idx          = err_idx_q;

endmodule

// File: tb/tb_adam_pause_seq.sv
// Directed bench for adam_pause_seq: model peripherals with per-index ack latency, a monitor
// that logs output edges, and a scoreboard of expected edges per phase.
module tb_adam_pause_seq;

  localparam int unsigned N   = 4;
  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adam_pause_seq_if #(.NO_PERIPHS(N)) bus_if ();

  adam_pause_seq #(
    .NO_PERIPHS(N),
    .TIMEOUT   (TMO)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int base    = 0;
  bit mon_en  = 1'b0;

  int dly [N];  // ack latency per peripheral, 0 = never acks
  int pc  [N];

  int exp_q [$];
  int obs_q [$];

  logic [N-1:0] prev_req = '0;
  logic         prev_ack = 1'b0;
  logic         prev_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral model: ack follows req after dly cycles.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (dly[i] == 0) begin
        bus_if.periph_pause_ack[i] <= 1'b0;
        pc[i] <= 0;
      end else if (bus_if.periph_pause_ack[i] !== bus_if.periph_pause_req[i]) begin
        if (pc[i] + 1 >= dly[i]) begin
          bus_if.periph_pause_ack[i] <= bus_if.periph_pause_req[i];
          pc[i] <= 0;
        end else begin
          pc[i] <= pc[i] + 1;
        end
      end else begin
        pc[i] <= 0;
      end
    end
  end

  // Event code: rel_edge*1000 + kind*100 + idx; kinds 1/2 req rise/fall, 3/4 ack, 5/6 err.
  function automatic int ev(input int rel, input int kind, input int idx);
    return rel * 1000 + kind * 100 + idx;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < N; i++)
        if (bus_if.periph_pause_req[i] !== prev_req[i])
          obs_q.push_back(ev(cyc - base, bus_if.periph_pause_req[i] ? 1 : 2, i));
      if (bus_if.pause_ack !== prev_ack) obs_q.push_back(ev(cyc - base, bus_if.pause_ack ? 3 : 4, 0));
      if (bus_if.err !== prev_err) obs_q.push_back(ev(cyc - base, bus_if.err ? 5 : 6, 0));
    end
    prev_req <= bus_if.periph_pause_req;
    prev_ack <= bus_if.pause_ack;
    prev_err <= bus_if.err;
  end

  task automatic start_phase();
    obs_q.delete();
    exp_q.delete();
    base = cyc + 1;
  endtask

  task automatic expect_ev(input int rel, input int kind, input int idx);
    exp_q.push_back(ev(rel, kind, idx));
  endtask

  task automatic check_phase(input string tag);
    int o, e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      n_tests++;
      assert (o === e) else begin
        n_fail++;
        $error("FAIL %s: event got %0d want %0d", tag, o, e);
      end
    end
    n_tests++;
    assert (obs_q.size() === 0) else begin
      n_fail++;
      $error("FAIL %s: %0d extra events got, 0 want, first %0d", tag, obs_q.size(), obs_q[0]);
    end
  endtask

  task automatic check_lvl(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic exp_full_pause();
    expect_ev(0, 1, 0);
    expect_ev(2, 1, 1);
    expect_ev(4, 1, 2);
    expect_ev(6, 1, 3);
    expect_ev(8, 3, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus_if.pause_req = 1'b0;
    bus_if.skip = '0;
    for (int i = 0; i < N; i++) dly[i] = 1;
    repeat (3) @(negedge clk);
    check_lvl("rst_req", 32'(bus_if.periph_pause_req), 32'h0);
    check_lvl("rst_ack", 32'(bus_if.pause_ack), 32'h0);
    check_lvl("rst_err", 32'(bus_if.err), 32'h0);
    check_lvl("rst_err_idx", 32'(bus_if.err_idx), 32'h0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Plain pause then release.
    start_phase();
    exp_full_pause();
    bus_if.pause_req = 1'b1;
    repeat (12) @(negedge clk);
    check_phase("pause_order");
    check_lvl("paused_ack", 32'(bus_if.pause_ack), 32'h1);

    start_phase();
    expect_ev(0, 2, 3);
    expect_ev(2, 2, 2);
    expect_ev(4, 2, 1);
    expect_ev(6, 2, 0);
    expect_ev(8, 4, 0);
    bus_if.pause_req = 1'b0;
    repeat (12) @(negedge clk);
    check_phase("resume_order");

    // Skip mask 0101.
    bus_if.skip = 4'b0101;
    start_phase();
    expect_ev(1, 1, 1);
    expect_ev(4, 1, 3);
    expect_ev(6, 3, 0);
    bus_if.pause_req = 1'b1;
    repeat (10) @(negedge clk);
    check_phase("skip_pause");

    start_phase();
    expect_ev(0, 2, 3);
    expect_ev(3, 2, 1);
    expect_ev(6, 4, 0);
    bus_if.pause_req = 1'b0;
    repeat (10) @(negedge clk);
    check_phase("skip_resume");
    bus_if.skip = '0;

    // Peripheral 2 never acks.
    dly[2] = 0;
    start_phase();
    expect_ev(0, 1, 0);
    expect_ev(2, 1, 1);
    expect_ev(4, 1, 2);
    expect_ev(4 + TMO, 1, 3);
    expect_ev(4 + TMO, 5, 0);
    expect_ev(6 + TMO, 3, 0);
    bus_if.pause_req = 1'b1;
    repeat (26) @(negedge clk);
    check_phase("tmo_pause");
    check_lvl("tmo_err_idx", 32'(bus_if.err_idx), 32'h2);

    start_phase();
    expect_ev(0, 2, 3);
    expect_ev(2, 2, 2);
    expect_ev(3, 2, 1);
    expect_ev(5, 2, 0);
    expect_ev(7, 4, 0);
    bus_if.pause_req = 1'b0;
    repeat (10) @(negedge clk);
    check_phase("tmo_resume");
    check_lvl("tmo_err_sticky", 32'(bus_if.err), 32'h1);

    // Abort while waiting on a slow peripheral 2.
    dly[2] = 10;
    start_phase();
    expect_ev(0, 1, 0);
    expect_ev(2, 1, 1);
    expect_ev(4, 1, 2);
    expect_ev(8, 2, 2);
    expect_ev(9, 2, 1);
    expect_ev(11, 2, 0);
    bus_if.pause_req = 1'b1;
    repeat (8) @(negedge clk);
    bus_if.pause_req = 1'b0;
    repeat (10) @(negedge clk);
    check_phase("abort_pause");
    check_lvl("abort_ack", 32'(bus_if.pause_ack), 32'h0);
    check_lvl("abort_err_sticky", 32'(bus_if.err), 32'h1);
    dly[2] = 1;

    // Re-raise during resume at idx 1.
    start_phase();
    exp_full_pause();
    bus_if.pause_req = 1'b1;
    repeat (12) @(negedge clk);
    check_phase("repause_pre");

    start_phase();
    expect_ev(0, 2, 3);
    expect_ev(2, 2, 2);
    expect_ev(4, 2, 1);
    expect_ev(5, 1, 1);
    expect_ev(5, 4, 0);
    expect_ev(7, 1, 2);
    expect_ev(9, 1, 3);
    expect_ev(11, 3, 0);
    bus_if.pause_req = 1'b0;
    repeat (5) @(negedge clk);
    bus_if.pause_req = 1'b1;
    repeat (10) @(negedge clk);
    check_phase("abort_resume");
    check_lvl("repause_ack", 32'(bus_if.pause_ack), 32'h1);

    // Reset while paused, pause_req held high.
    start_phase();
    for (int i = 0; i < N; i++) expect_ev(0, 2, i);
    expect_ev(0, 4, 0);
    expect_ev(0, 6, 0);
    expect_ev(1, 1, 0);
    expect_ev(3, 1, 1);
    expect_ev(5, 1, 2);
    expect_ev(7, 1, 3);
    expect_ev(9, 3, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_lvl("mid_rst_err_idx", 32'(bus_if.err_idx), 32'h0);
    check_lvl("mid_rst_req", 32'(bus_if.periph_pause_req), 32'h0);
    repeat (12) @(negedge clk);
    check_phase("reset_repause");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
